ssd_scan_drv: RTL and testbench

SSD_SCAN_DRV -- requirements
Module: ssd_scan_drv

---
 rtl/ssd_pkg.sv | 37 +++
 rtl/ssd_hex_lut.sv | 16 +
 rtl/ssd_scan_drv.sv | 184 ++++++++++++++++++
 tb/tb_ssd_scan_drv.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ssd_pkg.sv
// ----------------------------------------------------------------------------
// ssd_pkg
// Shared definitions for the seven-segment scan driver.
//   SEG_BLANK : cathode pattern with every segment off (active-low)
//   HEX_SEG   : 16-entry nibble-to-segment table, bit order g..a (bit 6 = g),
//               active-low
//   idx_width : width of the digit index register for a given digit count
// ----------------------------------------------------------------------------
package ssd_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [6:0] HEX_SEG [16] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000,  // 9
    7'b0001000,  // A
    7'b0000011,  // b
    7'b1000110,  // C
    7'b0100001,  // d
    7'b0000110,  // E
    7'b0001110   // F
  };

  // At least one bit so a two-digit build still has a real index register.
  function automatic int idx_width(input int num_digits);
    return (num_digits <= 2) ? 1 : $clog2(num_digits);
  endfunction

endpackage

// File: rtl/ssd_hex_lut.sv
// ----------------------------------------------------------------------------
// ssd_hex_lut
// Combinational hex nibble to seven-segment lookup.
//   nibble : input  [3:0] hex value to display
//   seg    : output [6:0] segments g..a, active-low
// ----------------------------------------------------------------------------
module ssd_hex_lut
  import ssd_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/ssd_scan_drv.sv
// ----------------------------------------------------------------------------
// ssd_scan_drv
// Time-multiplexed seven-segment display driver with double-buffered value
// register. Each digit owns a slot of REFRESH_DIV cycles; the first
// GUARD_CYCLES of every slot keep all anodes off to avoid ghosting. A new
// value captured by i_Load waits in a pending register and is promoted to the
// displayed (active) register only on a frame boundary, so a frame never
// mixes old and new digits.
//
// Parameters:
//   NUM_DIGITS   : number of digits (2..8)
//   REFRESH_DIV  : clock cycles per digit slot (4..2^24)
//   GUARD_CYCLES : anode-off cycles at the start of each slot
//
// Ports:
//   i_CLK      : clock, rising edge
//   i_RST      : synchronous active-high reset
//   i_Value    : hex nibbles, nibble k drives digit k (digit 0 rightmost)
//   i_DP       : per-digit decimal point, active-high
//   i_Blank    : per-digit force-blank, active-high, used live
//   i_Load     : one-cycle strobe capturing i_Value / i_DP
//   o_Cathodes : segments g..a, active-low
//   o_DP       : decimal-point segment, active-low
//   o_Anodes   : digit enables, active-low, at most one low
//   o_Pending  : a captured load is waiting for the frame boundary
//   o_Frame    : one-cycle pulse following each frame boundary
//
// Build option:
//   SSD_LZB_EN : when defined, digits above the highest non-zero nibble of
//                the active value are blanked (digit 0 is never blanked).
// ----------------------------------------------------------------------------
module ssd_scan_drv
  import ssd_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int GUARD_CYCLES = 2
) (
  input  logic                    i_CLK,
  input  logic                    i_RST,
  input  logic [4*NUM_DIGITS-1:0] i_Value,
  input  logic [NUM_DIGITS-1:0]   i_DP,
  input  logic [NUM_DIGITS-1:0]   i_Blank,
  input  logic                    i_Load,
  output logic [6:0]              o_Cathodes,
  output logic                    o_DP,
  output logic [NUM_DIGITS-1:0]   o_Anodes,
  output logic                    o_Pending,
  output logic                    o_Frame
);

  localparam int IDX_W  = idx_width(NUM_DIGITS);
  localparam int SLOT_W = $clog2(REFRESH_DIV);

  logic [SLOT_W-1:0]       slot_cnt;
  logic [IDX_W-1:0]        idx;
  logic [4*NUM_DIGITS-1:0] act_val;
  logic [NUM_DIGITS-1:0]   act_dp;
  logic [4*NUM_DIGITS-1:0] pend_val;
  logic [NUM_DIGITS-1:0]   pend_dp;
  logic                    pending;

  logic                    slot_wrap;
  logic                    frame_end;
  logic [3:0]              cur_nibble;
  logic                    cur_dp;
  logic                    cur_blank;
  logic [6:0]              cur_seg;
  logic [NUM_DIGITS-1:0]   lzb_mask;

  assign slot_wrap = (slot_cnt == SLOT_W'(REFRESH_DIV - 1));
  assign frame_end = slot_wrap && (idx == IDX_W'(NUM_DIGITS - 1));

  // --------------------------------------------------------------------------
  // Slot counter and digit index
  // --------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      slot_cnt <= '0;
      idx      <= '0;
    end else if (slot_wrap) begin
      slot_cnt <= '0;
      idx      <= frame_end ? '0 : idx + 1'b1;
    end else begin
      slot_cnt <= slot_cnt + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Double buffer: loads land in pending, promoted only at the frame boundary.
  // A load on the boundary cycle itself bypasses pending so it is not held
  // back a whole extra frame.
  // --------------------------------------------------------------------------
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      act_val  <= '0;
      act_dp   <= '0;
      pend_val <= '0;
      pend_dp  <= '0;
      pending  <= 1'b0;
    end else if (i_Load) begin
      if (frame_end) begin
        act_val <= i_Value;
        act_dp  <= i_DP;
        pending <= 1'b0;
      end else begin
        pend_val <= i_Value;
        pend_dp  <= i_DP;
        pending  <= 1'b1;
      end
    end else if (frame_end && pending) begin
      act_val <= pend_val;
      act_dp  <= pend_dp;
      pending <= 1'b0;
    end
  end

  assign o_Pending = pending;

  // --------------------------------------------------------------------------
  // Leading-zero blanking mask (bit k set => digit k suppressed)
  // --------------------------------------------------------------------------
`ifdef SSD_LZB_EN
  logic zero_run;

  always_comb begin
    lzb_mask = '0;
    zero_run = 1'b1;
    // Walk down from the most significant digit; stop at digit 1 so the
    // rightmost digit always shows, even for a value of zero.
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      zero_run    = zero_run && (act_val[4*k +: 4] == 4'h0);
      lzb_mask[k] = zero_run;
    end
  end
`else
  assign lzb_mask = '0;
`endif

  // --------------------------------------------------------------------------
  // Current digit selection
  // --------------------------------------------------------------------------
  // NOTE: every output of a combinational block gets a default up front so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    cur_nibble = 4'h0;
    cur_dp     = 1'b0;
    cur_blank  = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx == IDX_W'(k)) begin
        cur_nibble = act_val[4*k +: 4];
        cur_dp     = act_dp[k];
        cur_blank  = i_Blank[k] || lzb_mask[k];
      end
    end
  end

  ssd_hex_lut u_hex_lut (
    .nibble (cur_nibble),
    .seg    (cur_seg)
  );

  // --------------------------------------------------------------------------
  // Registered outputs, one cycle behind the counter/index state
  // --------------------------------------------------------------------------
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      o_Anodes   <= '1;
      o_Cathodes <= SEG_BLANK;
      o_DP       <= 1'b1;
      o_Frame    <= 1'b0;
    end else begin
      o_Anodes   <= (slot_cnt < SLOT_W'(GUARD_CYCLES)) ? '1
                                                       : ~(NUM_DIGITS'(1) << idx);
      o_Cathodes <= cur_blank ? SEG_BLANK : cur_seg;
      // A blanked digit never shows its decimal point.
      o_DP       <= cur_blank || !cur_dp;
      o_Frame    <= frame_end;
    end
  end

endmodule

// File: tb/tb_ssd_scan_drv.sv
// ----------------------------------------------------------------------------
// tb_ssd_scan_drv
// Self-checking bench for ssd_scan_drv with NUM_DIGITS=4, REFRESH_DIV=8,
// GUARD_CYCLES=2. A time-based reference model (position derived from cycles
// since reset) pushes the expected registered outputs into a scoreboard queue
// each cycle; they are popped and compared once the DUT has produced them.
// Directed checks add fixed expectations for the scan pattern, buffering,
// coincident load, blanking and (with SSD_LZB_EN) leading-zero blanking.
// ----------------------------------------------------------------------------
module tb_ssd_scan_drv;

  localparam int ND    = 4;
  localparam int DIV   = 8;
  localparam int GUARD = 2;
  localparam int FRAME = ND * DIV;

  logic        i_CLK = 1'b0;
  logic        i_RST;
  logic [15:0] i_Value;
  logic [3:0]  i_DP;
  logic [3:0]  i_Blank;
  logic        i_Load;
  logic [6:0]  o_Cathodes;
  logic        o_DP;
  logic [3:0]  o_Anodes;
  logic        o_Pending;
  logic        o_Frame;

  ssd_scan_drv #(
    .NUM_DIGITS   (ND),
    .REFRESH_DIV  (DIV),
    .GUARD_CYCLES (GUARD)
  ) dut (
    .i_CLK      (i_CLK),
    .i_RST      (i_RST),
    .i_Value    (i_Value),
    .i_DP       (i_DP),
    .i_Blank    (i_Blank),
    .i_Load     (i_Load),
    .o_Cathodes (o_Cathodes),
    .o_DP       (o_DP),
    .o_Anodes   (o_Anodes),
    .o_Pending  (o_Pending),
    .o_Frame    (o_Frame)
  );

  always #5 i_CLK = ~i_CLK;

  typedef struct packed {
    logic [3:0] anodes;
    logic [6:0] cath;
    logic       dp;
    logic       pend;
    logic       frame;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int          m_cnt;
  logic [15:0] m_act_val;
  logic [3:0]  m_act_dp;
  logic [15:0] m_pend_val;
  logic [3:0]  m_pend_dp;
  logic        m_pend;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  // Digit d is leading-zero blanked when it and every digit above it is zero.
  function automatic logic lz_blank(input logic [15:0] v, input int d);
    logic r;
    r = (d != 0);
    for (int k = d; k < ND; k++)
      if (v[4*k +: 4] != 4'h0) r = 1'b0;
`ifdef SSD_LZB_EN
    return r;
`else
    return 1'b0 & r;
`endif
  endfunction

  // One clock: predict, push, advance, pop and compare.
  task automatic step();
    exp_t       e;
    exp_t       got;
    int         slot;
    int         dig;
    logic       bnd;
    logic       blank;
    logic [3:0] onehot;
    if (i_RST) begin
      e          = '{anodes: 4'hF, cath: 7'h7F, dp: 1'b1, pend: 1'b0, frame: 1'b0};
      m_cnt      = 0;
      m_act_val  = '0;
      m_act_dp   = '0;
      m_pend_val = '0;
      m_pend_dp  = '0;
      m_pend     = 1'b0;
    end else begin
      slot     = m_cnt % DIV;
      dig      = (m_cnt / DIV) % ND;
      bnd      = ((m_cnt % FRAME) == FRAME - 1);
      blank    = i_Blank[dig] || lz_blank(m_act_val, dig);
      onehot   = 4'b0001 << dig;
      e.anodes = (slot < GUARD) ? 4'hF : ~onehot;
      e.cath   = blank ? 7'h7F : hex7(m_act_val[4*dig +: 4]);
      e.dp     = blank ? 1'b1 : !m_act_dp[dig];
      e.frame  = bnd;
      if (i_Load) begin
        if (bnd) begin
          m_act_val = i_Value;
          m_act_dp  = i_DP;
          m_pend    = 1'b0;
        end else begin
          m_pend_val = i_Value;
          m_pend_dp  = i_DP;
          m_pend     = 1'b1;
        end
      end else if (bnd && m_pend) begin
        m_act_val = m_pend_val;
        m_act_dp  = m_pend_dp;
        m_pend    = 1'b0;
      end
      e.pend = m_pend;
      m_cnt++;
    end
    sb.push_back(e);
    @(posedge i_CLK);
    #1;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      got = sb.pop_front();
      check("anodes",   {28'd0, o_Anodes},   {28'd0, got.anodes});
      check("cathodes", {25'd0, o_Cathodes}, {25'd0, got.cath});
      check("dp",       {31'd0, o_DP},       {31'd0, got.dp});
      check("pending",  {31'd0, o_Pending},  {31'd0, got.pend});
      check("frame",    {31'd0, o_Frame},    {31'd0, got.frame});
    end
  endtask

  task automatic load(input logic [15:0] v, input logic [3:0] dp);
    i_Value = v;
    i_DP    = dp;
    i_Load  = 1'b1;
    step();
    i_Load  = 1'b0;
  endtask

  task automatic step_to(input int phase);
    while ((m_cnt % FRAME) != phase) step();
  endtask

  // Observe whole frames starting at digit 0, slot 0. exp_cath holds digit k
  // at [7k +: 7]; exp_dp bit k is the required o_DP while digit k is lit.
  task automatic observe(input string tag, input int frames,
                         input logic [27:0] exp_cath, input logic [3:0] exp_dp);
    int         lit [ND];
    int         pulses;
    logic [3:0] onehot;
    step_to(0);
    for (int k = 0; k < ND; k++) lit[k] = 0;
    pulses = 0;
    for (int c = 0; c < frames * FRAME; c++) begin
      step();
      if (o_Frame) pulses++;
      for (int k = 0; k < ND; k++) begin
        onehot = 4'b0001 << k;
        if (o_Anodes == ~onehot) begin
          lit[k]++;
          check({tag, "_cath"}, {25'd0, o_Cathodes}, {25'd0, exp_cath[7*k +: 7]});
          check({tag, "_dp"},   {31'd0, o_DP},       {31'd0, exp_dp[k]});
        end
      end
    end
    for (int k = 0; k < ND; k++)
      check({tag, "_lit_cycles"}, lit[k], (DIV - GUARD) * frames);
    check({tag, "_frame_pulses"}, pulses, frames);
  endtask

  initial begin
    i_RST   = 1'b1;
    i_Value = '0;
    i_DP    = '0;
    i_Blank = '0;
    i_Load  = 1'b0;

    // Reset held for three cycles
    repeat (3) begin
      step();
      check("rst_anodes", {28'd0, o_Anodes},   32'hF);
      check("rst_cath",   {25'd0, o_Cathodes}, 32'h7F);
      check("rst_dp",     {31'd0, o_DP},       32'd1);
      check("rst_pend",   {31'd0, o_Pending},  32'd0);
    end
    i_RST = 1'b0;

    // Scan order and pattern over two frames
    load(16'hA8F0, 4'h0);
    observe("scan", 2, {7'b0001000, 7'b0000000, 7'b0001110, 7'b1000000}, 4'b1111);

    // Buffering: last load before the boundary wins, display holds until then
    step_to(10);
    load(16'h1111, 4'h0);
    check("buf_pend_set", {31'd0, o_Pending}, 32'd1);
    repeat (5) step();
    load(16'h2222, 4'h0);
    check("buf_pend_hold", {31'd0, o_Pending}, 32'd1);
    observe("buf", 1, {4{7'b0100100}}, 4'b1111);
    check("buf_pend_clr", {31'd0, o_Pending}, 32'd0);

    // Load coincident with the boundary goes straight to the display
    step_to(FRAME - 1);
    load(16'h0008, 4'h0);
    check("coin_pend", {31'd0, o_Pending}, 32'd0);
`ifdef SSD_LZB_EN
    observe("coin", 1, {7'h7F, 7'h7F, 7'h7F, 7'b0000000}, 4'b1111);
`else
    observe("coin", 1, {7'b1000000, 7'b1000000, 7'b1000000, 7'b0000000}, 4'b1111);
`endif

    // Forced blank on digit 2 with all decimal points on
    load(16'h1234, 4'hF);
    i_Blank = 4'b0100;
    observe("blank", 1, {7'b1111001, 7'h7F, 7'b0110000, 7'b0011001}, 4'b0100);
    i_Blank = 4'b0000;

    // All-zero value
    load(16'h0000, 4'h0);
`ifdef SSD_LZB_EN
    observe("zero", 1, {7'h7F, 7'h7F, 7'h7F, 7'b1000000}, 4'b1111);
    load(16'h0050, 4'h0);
    observe("lzb50", 1, {7'h7F, 7'h7F, 7'b0010010, 7'b1000000}, 4'b1111);
`else
    observe("zero", 1, {4{7'b1000000}}, 4'b1111);
`endif

    // Reset mid-frame discards the pending load and restarts at digit 0
    load(16'h7777, 4'h0);
    step_to(5);
    load(16'hFFFF, 4'hF);
    i_RST = 1'b1;
    repeat (2) step();
    check("mid_rst_pend", {31'd0, o_Pending}, 32'd0);
    i_RST = 1'b0;
`ifdef SSD_LZB_EN
    observe("post_rst", 1, {7'h7F, 7'h7F, 7'h7F, 7'b1000000}, 4'b1111);
`else
    observe("post_rst", 1, {4{7'b1000000}}, 4'b1111);
`endif
    check("post_rst_pend", {31'd0, o_Pending}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
